// File: rtl/lift_pkg.sv
// Shared floor constants, FSM state encoding and small helpers for the lift
// request manager and its companion lift controller.
package lift_pkg;
  localparam int NUM_FLOORS        = 4;
  localparam int FLOOR_W           = 2;
  localparam int CNT_W             = $clog2(NUM_FLOORS + 1);
  localparam int DEF_DOOR_CYCLES   = 8;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETTLE     = 2'd1,
    DOOR_OPEN  = 2'd2,
    DOOR_CLOSE = 2'd3
  } state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit    = '0;
    floor_bit[f] = 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_FLOORS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_FLOORS; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/btn_edge_detect.sv
// Per-bit rising-edge detector; history clears on reset so a button held
// through reset release registers as a fresh press.
module btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= btn;
  end

  assign rise = btn & ~prev;
endmodule

// File: rtl/lift_request_manager.sv
// Latches floor calls, presents them to the lift controller and sequences the
// door (settle, open with reopen-on-press, one-cycle close).
module lift_request_manager
  import lift_pkg::*;
#(
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] cab_btn,
  input  logic [NUM_FLOORS-1:0] hall_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  motor_stop,
  input  logic                  emergency_stop,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic                  door_open,
  output logic [CNT_W-1:0]      pending_cnt
);
  localparam int DW = $clog2(DOOR_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;

  logic [NUM_FLOORS-1:0] cab_rise, hall_rise, press, cur_bit, pending;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic [FLOOR_W-1:0]    settle_floor;
  logic [SW-1:0]         settle_cnt;
  logic [DW-1:0]         door_cnt;
  state_t                state;
  logic                  run, still, enter_door, reopen;

  btn_edge_detect #(.WIDTH(NUM_FLOORS)) u_cab_edge (
    .clk(clk), .reset(reset), .btn(cab_btn), .rise(cab_rise)
  );

  btn_edge_detect #(.WIDTH(NUM_FLOORS)) u_hall_edge (
    .clk(clk), .reset(reset), .btn(hall_btn), .rise(hall_rise)
  );

  assign press      = cab_rise | hall_rise;
  assign cur_bit    = floor_bit(current_floor);
  assign run        = !emergency_stop;
  assign still      = motor_stop && (current_floor == settle_floor);
  assign enter_door = run && (state == SETTLE) && still && (settle_cnt <= SW'(1));
  assign reopen     = (state == DOOR_OPEN) && |(press & cur_bit);

  // A press of the floor the door is open at only extends the door; the
  // clear on door entry beats a coincident press of the same floor.
  assign set_mask = press & ~((state == DOOR_OPEN) ? cur_bit : '0);
  assign clr_mask = enter_door ? cur_bit : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      settle_cnt   <= '0;
      door_cnt     <= '0;
      settle_floor <= '0;
      door_open    <= 1'b0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      if (run) begin
        case (state)
          IDLE: begin
            if (motor_stop && pending[current_floor]) begin
              state        <= SETTLE;
              settle_cnt   <= SW'(SETTLE_CYCLES);
              settle_floor <= current_floor;
            end
          end
          SETTLE: begin
            if (!still) begin
              state <= IDLE;
            end else if (enter_door) begin
              state     <= DOOR_OPEN;
              door_open <= 1'b1;
              door_cnt  <= DW'(DOOR_CYCLES);
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          DOOR_OPEN: begin
            if (reopen) begin
              door_cnt <= DW'(DOOR_CYCLES);
            end else if (door_cnt <= DW'(1)) begin
              state     <= DOOR_CLOSE;
              door_open <= 1'b0;
            end else begin
              door_cnt <= door_cnt - DW'(1);
            end
          end
          DOOR_CLOSE: state <= IDLE;
          default:    state <= IDLE;
        endcase
      end
    end
  end

  assign floor_req   = (run && (state == IDLE || state == SETTLE)) ? pending : '0;
  assign pending_cnt = popcount(pending);
endmodule
